turbo_itl_tx: RTL
=================

// Module: turbo_itl_tx
// PURPOSE
//  Transmit-side turbo channel interleaver for HPGP PB frames. Buffers one PB worth of
//  2-bit symbol pairs in natural order, then streams them out in interleaved order
//  I(k) = (S*k) mod L, the exact inverse of the receive-side de-interleaver.
//  Sits between the turbo encoder output and the TX mapper; one block in flight at a time.
// PARAMETERS
//  L16   64    pair count, PB16  (128 bits)
//  L136  544   pair count, PB136 (1088 bits)
//  L520  2080  pair count, PB520 (4160 bits)
//  S16   23    interleave step, PB16 (coprime with L16, < L16)
//  S136  171   interleave step, PB136 (coprime with L136, < L136)
//  S520  643   interleave step, PB520 (coprime with L520, < L520)
//  AW    12    RAM address width (2^AW >= L520)
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  n_rst     in   1   reset, synchronous, active-low
//  pb_size   in   2   0=PB16, 1=PB136, 2=PB520, 3=treated as PB520
//  din       in   2   symbol pair, natural order
//  din_vld   in   1   din valid; a write occurs only when din_vld & din_rdy
//  din_rdy   out  1   block can accept input (IDLE or WRITE)
//  dout      out  2   symbol pair, interleaved order
//  dout_vld  out  1   dout valid, one pair per cycle, no gaps within a block
//  dout_last out  1   high with dout_vld on pair k=L-1
// BEHAVIOUR
//  Clocking/reset: single clock clk; n_rst synchronous active-low. Reset: state=IDLE,
//   counters=0, din_rdy=1 from first cycle after reset, dout=0, dout_vld=0, dout_last=0.
//   RAM contents not cleared. Reset mid-WRITE/READ aborts the block; no further dout.
//  Storage: internal single-port-write/single-port-read RAM, depth 2^AW x 2, read data
//   registered (1-cycle read latency).
//  FSM IDLE -> WRITE -> READ -> IDLE:
//   IDLE : din_rdy=1. On din_vld: latch pb_size -> L,S; write din to addr 0; wcnt=1; ->WRITE.
//   WRITE: din_rdy=1. On din_vld: write addr wcnt, wcnt++. Write with wcnt==L-1 -> READ.
//          din_vld=0 cycles are bubbles; no timeout. pb_size changes ignored until IDLE.
//   READ : din_rdy=0, din_vld ignored. Issue one read per cycle, k=0..L-1, raddr=I(k).
//          After issuing k=L-1 -> IDLE.
//  Address gen: raddr starts at 0; next = raddr+S, minus L if >= L (single conditional
//   subtract, AW+1-bit sum). No multiplier.
//  Output timing: dout/dout_vld registered one cycle after each read issue. Last write
//   accepted at cycle T -> first dout_vld at T+2; dout_vld high for exactly L cycles.
//   dout_last on cycle T+L+1. dout holds its last value when dout_vld=0.
//  Overlap: final dout cycle coincides with IDLE; a new block may write addr 0 that cycle
//   without corrupting the output (read already issued).
//  Throughput: L write cycles (min) + L read cycles per block.
// TESTING
//  T1 PB16: pb_size=0, din=i mod 4 for i=0..63 back-to-back -> 64 dout_vld; first four dout
//     = 0,3,2,1 (addr 0,23,46,5); dout_last on 64th; first dout_vld 2 cycles after last write.
//  T2 PB136: pb_size=1, din=i mod 4 -> 544 outputs, addr 0,171,342,513,140 -> dout 0,3,2,1,0;
//     full compare vs model (S*k) mod L; every address read exactly once.
//  T3 PB520: pb_size=2 with random din_vld bubbles -> 2080 outputs, addr 0,643,1286,1929,492;
//     output identical to no-bubble run; din_rdy=0 for exactly 2080 READ cycles.
//  T4 Back-pressure: hold din_vld=1 through READ with changing din/pb_size -> ignored; next
//     block starts writing in IDLE on the last dout cycle; both blocks output correctly.
//  T5 Reset: assert n_rst=0 mid-READ of PB136 -> next cycle dout_vld=0, dout=0, din_rdy=1;
//     fresh PB16 block then outputs correctly.
//  T6 pb_size=3 -> behaves as PB520 (2080 outputs, step 643).

Source files
------------

// File: rtl/turbo_itl_tx_if.sv
`default_nettype none
// ============================================================================
// turbo_itl_tx_if : symbol-pair in/out bundle of the TX turbo interleaver
// Rev 1.0
// ============================================================================
interface turbo_itl_tx_if;
    logic [1:0] pb_size;
    logic [1:0] din;
    logic       din_vld;
    logic       din_rdy;
    logic [1:0] dout;
    logic       dout_vld;
    logic       dout_last;

    modport master (
        output pb_size, din, din_vld,
        input  din_rdy, dout, dout_vld, dout_last
    );

    modport slave (
        input  pb_size, din, din_vld,
        output din_rdy, dout, dout_vld, dout_last
    );
endinterface
`default_nettype wire

// File: rtl/turbo_itl_tx.sv
`default_nettype none
// ============================================================================
// turbo_itl_tx : buffers one PB of symbol pairs, replays them at (S*k) mod L
// Rev 1.0
// ============================================================================
module turbo_itl_tx #(
    parameter int L16  = 64,
    parameter int L136 = 544,
    parameter int L520 = 2080,
    parameter int S16  = 23,
    parameter int S136 = 171,
    parameter int S520 = 643,
    parameter int AW   = 12
) (
    input  logic           clk,
    input  logic           n_rst,
    turbo_itl_tx_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] len_q,   len_d;
    logic [AW-1:0] step_q,  step_d;
    logic [AW-1:0] wcnt_q,  wcnt_d;
    logic [AW-1:0] rcnt_q,  rcnt_d;
    logic [AW-1:0] raddr_q, raddr_d;

    logic          we;
    logic [AW-1:0] waddr;
    logic          rd_en;
    logic          rd_last;
    logic [AW:0]   sum;

    logic [1:0]    mem [2**AW];
    logic [1:0]    dout_q;
    logic          dout_vld_q;
    logic          dout_last_q;

    assign sum = {1'b0, raddr_q} + {1'b0, step_q};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        step_d  = step_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        raddr_d = raddr_q;
        we      = 1'b0;
        waddr   = wcnt_q;
        rd_en   = 1'b0;
        rd_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.din_vld) begin
                    case (bus.pb_size)
                        2'd0:    begin len_d = AW'(L16);  step_d = AW'(S16);  end
                        2'd1:    begin len_d = AW'(L136); step_d = AW'(S136); end
                        default: begin len_d = AW'(L520); step_d = AW'(S520); end
                    endcase
                    we      = 1'b1;
                    waddr   = '0;
                    wcnt_d  = AW'(1);
                    rcnt_d  = '0;
                    raddr_d = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.din_vld) begin
                    we     = 1'b1;
                    wcnt_d = wcnt_q + AW'(1);
                    if (wcnt_q == len_q - AW'(1)) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                rd_en   = 1'b1;
                rd_last = (rcnt_q == len_q - AW'(1));
                rcnt_d  = rcnt_q + AW'(1);
                // Step stays below L, so one conditional subtract keeps the address in range.
                raddr_d = (sum >= {1'b0, len_q}) ? AW'(sum - {1'b0, len_q}) : sum[AW-1:0];
                if (rd_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            step_q      <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            raddr_q     <= '0;
            dout_q      <= 2'b00;
            dout_vld_q  <= 1'b0;
            dout_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            step_q      <= step_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            raddr_q     <= raddr_d;
            dout_vld_q  <= rd_en;
            dout_last_q <= rd_en & rd_last;
            if (rd_en) begin
                dout_q <= mem[raddr_q];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (n_rst && we) begin
            mem[waddr] <= bus.din;
        end
    end

    assign bus.din_rdy   = (state_q == IDLE) || (state_q == WRITE);
    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.dout_last = dout_last_q;

endmodule
`default_nettype wire
